dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 17 +
 rtl/dmem_arbiter_cmd_reg.sv | 40 ++++
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and FSM state type for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int DMEM_WIDTH = 16;
    localparam int XLEN       = 32;
    localparam int SL_WIDTH   = 3;

    // Load/store size code for a full word access
    localparam logic [SL_WIDTH-1:0] SL_WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CORE = 2'b01,
        ST_DBG  = 2'b10
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_cmd_reg.sv
// Command register holding the granted memory command; loads on en.
module dmem_cmd_reg
    import dmem_arbiter_pkg::*;
#(
    parameter int AW = DMEM_WIDTH,
    parameter int DW = XLEN
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic                we_d,
    input  logic [AW-1:0]       addr_d,
    input  logic [DW-1:0]       wdata_d,
    input  logic [SL_WIDTH-1:0] lwhb_d,
    input  logic [SL_WIDTH-1:0] swhb_d,
    output logic                we_q,
    output logic [AW-1:0]       addr_q,
    output logic [DW-1:0]       wdata_q,
    output logic [SL_WIDTH-1:0] lwhb_q,
    output logic [SL_WIDTH-1:0] swhb_q
);

    // Capture the command on a grant; hold it stable for the whole access
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lwhb_q  <= '0;
            swhb_q  <= '0;
        end else if (en) begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lwhb_q  <= lwhb_d;
            swhb_q  <= swhb_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: the pipeline MEM stage (core) and a
// display/debug read port share one memory. The core normally wins; a
// starvation counter forces a debug grant after STARVE_MAX core grants.
//
// Handshake: a requester holds *_req high until its one-cycle *_done pulse.
// mem_req stays high with a stable command until mem_ack; mem_ack and
// mem_rdata are valid together and mem_ack is ignored while mem_req is low.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW         = DMEM_WIDTH,
    parameter int DW         = XLEN,
    parameter int STARVE_MAX = 8,
    localparam int CW        = $clog2(STARVE_MAX + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    // core port
    input  logic                core_req,
    input  logic                core_we,
    input  logic [AW-1:0]       core_addr,
    input  logic [DW-1:0]       core_wdata,
    input  logic [SL_WIDTH-1:0] core_lwhb,
    input  logic [SL_WIDTH-1:0] core_swhb,
    output logic [DW-1:0]       core_rdata,
    output logic                core_done,
    output logic                core_stall,
    // debug read port
    input  logic                dbg_req,
    input  logic [AW-1:0]       dbg_addr,
    output logic [DW-1:0]       dbg_rdata,
    output logic                dbg_done,
    // memory port
    output logic                mem_req,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    output logic [SL_WIDTH-1:0] mem_lwhb,
    output logic [SL_WIDTH-1:0] mem_swhb,
    input  logic                mem_ack,
    input  logic [DW-1:0]       mem_rdata,
    // observability
    output arb_state_t          fsm_state,
    output logic [CW-1:0]       starve_cnt
);

    arb_state_t          state, state_nxt;
    logic                grant_core, grant_dbg;
    logic                dbg_wins;
    logic                aborted;
    logic                cmd_we;
    logic [AW-1:0]       cmd_addr;
    logic [DW-1:0]       cmd_wdata;
    logic [SL_WIDTH-1:0] cmd_lwhb, cmd_swhb;

    assign dbg_wins  = dbg_req && (starve_cnt == CW'(STARVE_MAX));
    assign fsm_state = state;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Arbitration and access-completion transitions
    always_comb begin
        state_nxt  = state;
        grant_core = 1'b0;
        grant_dbg  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (core_req && !dbg_wins) begin
                    grant_core = 1'b1;
                    state_nxt  = ST_CORE;
                end else if (dbg_req) begin
                    grant_dbg  = 1'b1;
                    state_nxt  = ST_DBG;
                end
            end
            ST_CORE, ST_DBG: begin
                if (mem_ack) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Select the winning requester's command; debug is always a word read
    always_comb begin
        cmd_we    = 1'b0;
        cmd_addr  = dbg_addr;
        cmd_wdata = '0;
        cmd_lwhb  = SL_WORD;
        cmd_swhb  = '0;
        if (!grant_dbg) begin
            cmd_we    = core_we;
            cmd_addr  = core_addr;
            cmd_wdata = core_wdata;
            cmd_lwhb  = core_lwhb;
            cmd_swhb  = core_swhb;
        end
    end

    dmem_cmd_reg #(
        .AW(AW),
        .DW(DW)
    ) u_cmd_reg (
        .clk     (clk),
        .rstn    (rstn),
        .en      (grant_core | grant_dbg),
        .we_d    (cmd_we),
        .addr_d  (cmd_addr),
        .wdata_d (cmd_wdata),
        .lwhb_d  (cmd_lwhb),
        .swhb_d  (cmd_swhb),
        .we_q    (mem_we),
        .addr_q  (mem_addr),
        .wdata_q (mem_wdata),
        .lwhb_q  (mem_lwhb),
        .swhb_q  (mem_swhb)
    );

    // Remember a requester withdrawing mid-access so its late done is dropped
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aborted <= 1'b0;
        end else if (grant_core || grant_dbg) begin
            aborted <= 1'b0;
        end else if ((state == ST_CORE && !core_req) || (state == ST_DBG && !dbg_req)) begin
            aborted <= 1'b1;
        end
    end

    // Count core grants made while debug is waiting
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (!dbg_req || grant_dbg) begin
            starve_cnt <= '0;
        end else if (grant_core && starve_cnt != CW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Memory request and completion strobes derived from the current state
    always_comb begin
        mem_req    = (state != ST_IDLE);
        core_done  = (state == ST_CORE) && mem_ack && core_req && !aborted;
        dbg_done   = (state == ST_DBG) && mem_ack && dbg_req && !aborted;
        core_rdata = core_done ? mem_rdata : '0;
        core_stall = core_req && !core_done;
    end

    // Debug read data is registered and held until the next debug completion
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         dbg_rdata <= '0;
        else if (dbg_done) dbg_rdata <= mem_rdata;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by a
// randomized run, all compared against a transaction-level reference model.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW   = DMEM_WIDTH;
    localparam int DW   = XLEN;
    localparam int SMAX = 8;
    localparam int CW   = $clog2(SMAX + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic                core_req, core_we;
    logic [AW-1:0]       core_addr;
    logic [DW-1:0]       core_wdata;
    logic [SL_WIDTH-1:0] core_lwhb, core_swhb;
    logic [DW-1:0]       core_rdata;
    logic                core_done, core_stall;
    logic                dbg_req;
    logic [AW-1:0]       dbg_addr;
    logic [DW-1:0]       dbg_rdata;
    logic                dbg_done;
    logic                mem_req, mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [SL_WIDTH-1:0] mem_lwhb, mem_swhb;
    logic                mem_ack;
    logic [DW-1:0]       mem_rdata;
    arb_state_t          fsm_state;
    logic [CW-1:0]       starve_cnt;

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rstn(rstn),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_lwhb(core_lwhb), .core_swhb(core_swhb),
        .core_rdata(core_rdata), .core_done(core_done), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_lwhb(mem_lwhb), .mem_swhb(mem_swhb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fsm_state(fsm_state), .starve_cnt(starve_cnt)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];   // debug read data expected after each debug done
    int done_log[$];           // 1 = core done, 2 = debug done, in observed order

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int                  m_owner;   // 0 none, 1 core, 2 debug
    int                  m_starve;
    bit                  m_live;    // requester still wants the result
    int                  m_wait;    // cycles of mem_req before ack
    logic                m_we;
    logic [AW-1:0]       m_addr;
    logic [DW-1:0]       m_wdata;
    logic [SL_WIDTH-1:0] m_lwhb, m_swhb;
    logic [DW-1:0]       m_dbg_rdata;

    int            fixed_delay;     // -1 = random ack delay
    bit            fixed_data_en;
    logic [DW-1:0] fixed_data;
    bit            spurious_en;
    bit            e_core_done, e_dbg_done;
    logic          obs_stall, obs_done;
    int            n_core_done, n_dbg_done, n_mem_req;

    task automatic model_reset();
        m_owner = 0; m_starve = 0; m_live = 0; m_wait = 0;
        m_we = 1'b0; m_addr = '0; m_wdata = '0; m_lwhb = '0; m_swhb = '0;
        m_dbg_rdata = '0;
        exp_q.delete();
    endtask

    function automatic logic [1:0] exp_state();
        if (m_owner == 1) return ST_CORE;
        if (m_owner == 2) return ST_DBG;
        return ST_IDLE;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"},   mem_req, 0);
        check({tag, "_core_done"}, core_done, 0);
        check({tag, "_dbg_done"},  dbg_done, 0);
        check({tag, "_dbg_rdata"}, dbg_rdata, 0);
        check({tag, "_core_rdata"}, core_rdata, 0);
        check({tag, "_state"},     fsm_state, ST_IDLE);
        check({tag, "_starve"},    starve_cnt, 0);
        check({tag, "_cmd"},       {mem_we, mem_addr, mem_wdata, mem_lwhb, mem_swhb}, 0);
    endtask

    // ---------------- driver: one clock cycle, entered at posedge+1 ----------------
    task automatic cycle();
        bit g_core, g_dbg;
        if (m_owner != 0) mem_ack = (m_wait == 0);
        else              mem_ack = spurious_en && ($urandom_range(0, 5) == 0);
        mem_rdata = fixed_data_en ? fixed_data : DW'($urandom);
        #3;
        e_core_done = (m_owner == 1) && mem_ack && m_live && core_req;
        e_dbg_done  = (m_owner == 2) && mem_ack && m_live && dbg_req;
        check("mem_req",    mem_req, m_owner != 0);
        check("core_done",  core_done, e_core_done);
        check("dbg_done",   dbg_done, e_dbg_done);
        check("core_stall", core_stall, core_req && !e_core_done);
        check("core_rdata", core_rdata, e_core_done ? mem_rdata : '0);
        check("state",      fsm_state, exp_state());
        check("starve_cnt", starve_cnt, m_starve);
        check("mem_cmd", {mem_we, mem_addr, mem_wdata, mem_lwhb, mem_swhb},
              {m_we, m_addr, m_wdata, m_lwhb, m_swhb});
        if (exp_q.size() > 0) check("dbg_rdata_q", dbg_rdata, exp_q.pop_front());
        else                  check("dbg_rdata", dbg_rdata, m_dbg_rdata);
        obs_stall = core_stall;
        obs_done  = core_done;
        if (core_done) begin n_core_done++; done_log.push_back(1); end
        if (dbg_done)  begin n_dbg_done++;  done_log.push_back(2); end
        if (mem_req) n_mem_req++;

        // advance the model across the coming edge
        g_core = 0; g_dbg = 0;
        if (e_dbg_done) begin
            m_dbg_rdata = mem_rdata;
            exp_q.push_back(mem_rdata);
        end
        if (m_owner != 0) begin
            if (!((m_owner == 1) ? core_req : dbg_req)) m_live = 0;
            if (mem_ack) m_owner = 0;
            else         m_wait--;
        end else if (core_req && !(dbg_req && m_starve == SMAX)) begin
            g_core = 1;
        end else if (dbg_req) begin
            g_dbg = 1;
        end
        if (!dbg_req || g_dbg)            m_starve = 0;
        else if (g_core && m_starve < SMAX) m_starve++;
        if (g_core || g_dbg) begin
            m_owner = g_core ? 1 : 2;
            m_live  = 1;
            m_wait  = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
            m_we    = g_core ? core_we : 1'b0;
            m_addr  = g_core ? core_addr : dbg_addr;
            m_wdata = g_core ? core_wdata : '0;
            m_lwhb  = g_core ? core_lwhb : SL_WORD;
            m_swhb  = g_core ? core_swhb : '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic new_core_cmd();
        core_we    = 1'($urandom_range(0, 1));
        core_addr  = AW'($urandom);
        core_wdata = DW'($urandom);
        core_lwhb  = SL_WIDTH'($urandom_range(0, 7));
        core_swhb  = SL_WIDTH'($urandom_range(0, 7));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        rstn = 1'b0;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        core_lwhb = '0; core_swhb = '0;
        dbg_req = 0; dbg_addr = '0; mem_ack = 0; mem_rdata = '0;
        fixed_delay = 1; fixed_data_en = 0; fixed_data = '0; spurious_en = 0;
        n_core_done = 0; n_dbg_done = 0; n_mem_req = 0;
        model_reset();
        #2;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rstn = 1'b1;
        cycle();
        cycle();

        // Single core store, ack one cycle after mem_req rises
        core_req = 1; core_we = 1; core_addr = AW'(16'h0010); core_wdata = 32'hDEADBEEF;
        core_lwhb = SL_WORD; core_swhb = SL_WORD; fixed_delay = 1;
        cycle();
        check("store_c0_stall", obs_stall, 1);
        check("store_c0_done", obs_done, 0);
        cycle();
        check("store_c1_stall", obs_stall, 1);
        check("store_c1_done", obs_done, 0);
        check("store_wdata", mem_wdata, 32'hDEADBEEF);
        check("store_addr", mem_addr, 16'h0010);
        check("store_we", mem_we, 1);
        cycle();
        check("store_c2_done", obs_done, 1);
        check("store_c2_stall", obs_stall, 0);
        core_req = 0;
        cycle();

        // Contention: both held, eight core grants then one debug grant
        done_log.delete();
        core_req = 1; core_we = 0; dbg_req = 1; dbg_addr = AW'(16'h0020);
        k = 0;
        while (done_log.size() < 18 && k < 300) begin cycle(); k++; end
        check("contention_budget", done_log.size() >= 18, 1);
        for (int i = 0; i < 18 && i < done_log.size(); i++)
            check("contention_order", done_log[i], (i % 9 == 8) ? 2 : 1);
        core_req = 0; dbg_req = 0;
        k = 0;
        while (m_owner != 0 && k < 20) begin cycle(); k++; end
        cycle();

        // Debug read with a three-cycle ack delay
        n_dbg_done = 0;
        dbg_req = 1; dbg_addr = AW'(16'h0004);
        fixed_delay = 3; fixed_data_en = 1; fixed_data = 32'h12345678;
        k = 0;
        while (n_dbg_done == 0 && k < 20) begin cycle(); k++; end
        check("dbg_latency", k, 5);
        check("dbg_lwhb", mem_lwhb, SL_WORD);
        check("dbg_addr", mem_addr, 16'h0004);
        dbg_req = 0; fixed_data_en = 0; spurious_en = 1;
        repeat (4) cycle();
        check("dbg_done_count", n_dbg_done, 1);
        check("dbg_rdata_hold", dbg_rdata, 32'h12345678);
        spurious_en = 0;

        // Flush: core load withdrawn one cycle after grant
        core_req = 1; new_core_cmd(); core_we = 0; fixed_delay = 2;
        cycle();
        core_req = 0; n_core_done = 0; n_mem_req = 0;
        k = 0;
        while (m_owner != 0 && k < 10) begin cycle(); k++; end
        repeat (2) cycle();
        check("flush_no_done", n_core_done, 0);
        check("flush_mem_req_cycles", n_mem_req, 3);

        // Reset while a debug access is waiting for its ack
        dbg_req = 1; dbg_addr = AW'(16'h0008); fixed_delay = 3;
        cycle();
        cycle();
        check("pre_reset_mem_req", mem_req, 1);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        check("midreset_stall", core_stall, 0);
        model_reset();
        dbg_req = 0; mem_ack = 0;
        @(posedge clk); #1;
        rstn = 1'b1;
        cycle();

        // Randomized traffic with random ack delays and stray acks
        fixed_delay = -1; spurious_en = 1;
        for (int n = 0; n < 800; n++) begin
            if (core_req && e_core_done) begin
                core_req = 1'($urandom_range(0, 1));
                if (core_req) new_core_cmd();
            end else if (core_req && m_owner == 1 && $urandom_range(0, 15) == 0) begin
                core_req = 0;
            end else if (!core_req && $urandom_range(0, 2) == 0) begin
                core_req = 1;
                new_core_cmd();
            end
            if (dbg_req && e_dbg_done) begin
                dbg_req = 1'($urandom_range(0, 1));
                dbg_addr = AW'($urandom);
            end else if (dbg_req && m_owner == 2 && $urandom_range(0, 15) == 0) begin
                dbg_req = 0;
            end else if (!dbg_req && $urandom_range(0, 3) == 0) begin
                dbg_req = 1;
                dbg_addr = AW'($urandom);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the run ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
